adc_sample_framer: RTL and testbench
====================================

Name: adc_sample_framer

Overview:
- Upstream front end of the memory controller.
- Drives an external serial ADC (SPI-style, mode 0, MSB first) at a fixed sample rate.
- Deserializes each 16-bit conversion and presents it as a parallel sample with a one-cycle strobe.
- The strobe drives the memory controller's adc_clock input; the sample drives its record/write data path.

Parameters:
- DATA_W, 16: bits per conversion and width of sample_out.
- CLK_DIV, 4: clk cycles per sclk half-period; must be >= 1.
- SAMPLE_PERIOD, 1024: clk cycles between conversion starts; must be >= CLK_DIV*(2*DATA_W+1)+4.
- SIGNED_OUT, 1: 1 converts offset-binary ADC code to two's complement by inverting the MSB; 0 passes the code through unchanged.

Ports:
- clk  input  1  system clock; the single clock domain.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  permits new conversions to start at period boundaries.
- overrun_clr  input  1  one-cycle pulse that clears overrun.
- adc_sdo  input  1  serial data from the ADC; already synchronized to clk externally.
- adc_cs_n  output  1  ADC chip select, active low.
- adc_sclk  output  1  ADC serial clock; idles low.
- sample_out  output  DATA_W  last completed sample; held between strobes.
- sample_strobe  output  1  one-cycle pulse; sample_out is valid in the same cycle. Connects to adc_clock.
- busy  output  1  high while a conversion is in progress (cs_n low).
- overrun  output  1  sticky flag: a period boundary occurred while busy.

Behaviour:
Reset (async, rst_n=0):
- adc_cs_n=1, adc_sclk=0, sample_out=0, sample_strobe=0, busy=0, overrun=0.
- Period counter=0, state=IDLE, shift register=0.

Period counter:
- Free-running, counts 0..SAMPLE_PERIOD-1 and wraps to 0.
- Runs regardless of enable.
- The cycle in which the counter reads 0 is the tick.

State machine: IDLE -> SETUP -> SHIFT -> DONE -> IDLE.
- IDLE: on tick with enable=1, go to SETUP and drive adc_cs_n=0 and busy=1 from the next cycle.
- SETUP: hold sclk low for CLK_DIV cycles, then go to SHIFT.
- SHIFT: toggle adc_sclk every CLK_DIV cycles.
  - On each cycle where sclk rises, shift adc_sdo into the register LSB; first bit captured is the MSB.
  - After the DATA_W-th rising edge and the following falling edge, go to DONE.
  - Exactly DATA_W rising edges occur per conversion.
- DONE (one cycle):
  - adc_cs_n=1, busy=0.
  - sample_out <= shift register, with MSB inverted if SIGNED_OUT=1.
  - sample_strobe=1 for this cycle only.
  - Return to IDLE.
- Latency: sample_strobe asserts exactly CLK_DIV*(2*DATA_W+1)+1 cycles after the first cycle with adc_cs_n=0. Defaults give 133 cycles.

Boundary conditions:
- Tick while not IDLE: set overrun=1. The in-flight conversion is not disturbed and no extra conversion is queued.
- overrun_clr and an overrun event in the same cycle: set wins.
- enable deasserted mid-conversion: the conversion completes and strobes normally; no new start occurs.
- enable asserted off-tick: the first start waits for the next tick.
- rst_n low mid-conversion: everything returns to reset values immediately, with a partial sample discarded, and no strobe is produced.
- sample_strobe never asserts on two consecutive cycles; sample_out changes only in DONE.
- Shift register is DATA_W wide; there is no arithmetic beyond the MSB inversion and no saturation.

Test Plan:
1. Reset then enable=1, defaults, ADC model returns 16'hA5C3:
   - First adc_cs_n fall one cycle after counter=0.
   - Exactly 16 sclk rising edges.
   - sample_strobe pulse 133 cycles after cs_n fall.
   - sample_out=16'h25C3 (SIGNED_OUT=1).
   - Repeat with SIGNED_OUT=0: sample_out=16'hA5C3.
2. Continuous run, model returns 16'h0000, 16'hFFFF, 16'h8000:
   - sample_out=16'h8000, 16'h7FFF, 16'h0000.
   - Strobes exactly 1024 cycles apart.
   - overrun stays 0.
3. SAMPLE_PERIOD=64, CLK_DIV=4 (conversion longer than the period):
   - overrun=1 on the first tick during busy.
   - The next conversion starts only at the tick after DONE.
   - overrun_clr pulse returns overrun to 0.
   - overrun_clr on the same cycle as a new overrun event leaves overrun=1.
4. enable dropped 10 cycles after cs_n falls:
   - The current sample still strobes.
   - No further cs_n activity for 3 periods.
   - Re-enable mid-period: start waits for the next tick.
5. rst_n pulsed low at the 8th sclk rising edge:
   - Outputs at reset values within the same cycle.
   - No strobe; sample_out=0.
   - After release with enable=1, a normal conversion occurs at the next tick.

Source files
------------

// File: rtl/adc_sample_framer.sv
// Serial ADC front end: starts a conversion every SAMPLE_PERIOD cycles, clocks in DATA_W bits
// MSB first (SPI mode 0), and presents each completed sample with a one-cycle strobe.
module adc_sample_framer #(
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned SAMPLE_PERIOD = 1024,
    parameter bit          SIGNED_OUT    = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              overrun_clr,
    input  logic              adc_sdo,
    output logic              adc_cs_n,
    output logic              adc_sclk,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_strobe,
    output logic              busy,
    output logic              overrun
);

    localparam int unsigned PER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(DATA_W + 1);
    localparam logic [DATA_W-1:0] MSB_FLIP = SIGNED_OUT ? {1'b1, {(DATA_W-1){1'b0}}} : '0;

    typedef enum logic [1:0] {StIdle, StSetup, StShift, StDone} state_e;

    state_e            state_q, state_d;
    logic [PER_W-1:0]  period_q;
    logic [DIV_W-1:0]  div_q;
    logic [BIT_W-1:0]  bits_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] sample_q;
    logic              sclk_q;
    logic              strobe_q;
    logic              overrun_q;

    logic tick;
    logic div_last;
    logic all_bits;
    logic active;
    logic sclk_rise;
    logic sclk_fall;

    assign tick     = (period_q == '0);
    assign div_last = (div_q == DIV_W'(CLK_DIV - 1));
    assign all_bits = (bits_q == BIT_W'(DATA_W));

    // The end of SETUP doubles as the first rising edge; SHIFT ends after a full low half-period.
    assign sclk_rise = div_last && ((state_q == StSetup) ||
                                    (state_q == StShift && !sclk_q && !all_bits));
    assign sclk_fall = div_last && (state_q == StShift) && sclk_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= '0;
        end else if (period_q == PER_W'(SAMPLE_PERIOD - 1)) begin
            period_q <= '0;
        end else begin
            period_q <= period_q + PER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (tick && enable) state_d = StSetup;
            StSetup: if (div_last) state_d = StShift;
            StShift: if (div_last && !sclk_q && all_bits) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        active   = (state_q == StSetup) || (state_q == StShift);
        busy     = active;
        adc_cs_n = !active;
        adc_sclk = sclk_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            bits_q    <= '0;
            shift_q   <= '0;
            sample_q  <= '0;
            sclk_q    <= 1'b0;
            strobe_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (active) begin
                div_q <= div_last ? '0 : div_q + DIV_W'(1);
            end else begin
                div_q <= '0;
            end

            if (sclk_rise) begin
                sclk_q  <= 1'b1;
                shift_q <= {shift_q[DATA_W-2:0], adc_sdo};
            end else if (sclk_fall) begin
                sclk_q <= 1'b0;
            end

            if (state_q == StIdle) begin
                bits_q <= '0;
            end else if (sclk_rise) begin
                bits_q <= bits_q + BIT_W'(1);
            end

            strobe_q <= (state_q == StDone);
            if (state_q == StDone) begin
                sample_q <= shift_q ^ MSB_FLIP;
            end

            // A new overrun event takes priority over a clear in the same cycle.
            if (tick && state_q != StIdle) begin
                overrun_q <= 1'b1;
            end else if (overrun_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign sample_out    = sample_q;
    assign sample_strobe = strobe_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_adc_sample_framer.sv
// Bench for adc_sample_framer: three instances (signed, unsigned, short period) driven by an
// ADC model, checked against timing and sample values derived from the conversion rules.
module tb_adc_sample_framer;

    localparam int P   = 1024;
    localparam int P2  = 64;
    localparam int LAT = 4 * (2 * 16 + 1) + 1;
    localparam int NV  = 8;

    typedef struct {
        logic [15:0] word;
        logic [15:0] exp_s;
        logic [15:0] exp_u;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en[3];
    logic        clr[3];
    logic        sdo[3];
    logic        cs_n[3];
    logic        sclk[3];
    logic        strobe[3];
    logic        busy[3];
    logic        ovr[3];
    logic [15:0] sample[3];

    logic [15:0] adc_word[3];
    logic [15:0] cur_word[3];
    int          rises[3];
    logic        cs_prev[3];
    logic        sclk_prev[3];
    logic        strobe_prev[3];

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adc_sample_framer #(.SIGNED_OUT(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(en[0]), .overrun_clr(clr[0]), .adc_sdo(sdo[0]),
        .adc_cs_n(cs_n[0]), .adc_sclk(sclk[0]), .sample_out(sample[0]),
        .sample_strobe(strobe[0]), .busy(busy[0]), .overrun(ovr[0])
    );

    adc_sample_framer #(.SIGNED_OUT(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(en[1]), .overrun_clr(clr[1]), .adc_sdo(sdo[1]),
        .adc_cs_n(cs_n[1]), .adc_sclk(sclk[1]), .sample_out(sample[1]),
        .sample_strobe(strobe[1]), .busy(busy[1]), .overrun(ovr[1])
    );

    adc_sample_framer #(.SAMPLE_PERIOD(P2), .CLK_DIV(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .enable(en[2]), .overrun_clr(clr[2]), .adc_sdo(sdo[2]),
        .adc_cs_n(cs_n[2]), .adc_sclk(sclk[2]), .sample_out(sample[2]),
        .sample_strobe(strobe[2]), .busy(busy[2]), .overrun(ovr[2])
    );

    // ADC model: latches its word when cs_n falls, presents bit (15 - rises) until the next rise.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            cs_prev[i]   <= cs_n[i];
            sclk_prev[i] <= sclk[i];
            if (cs_n[i]) rises[i] <= 0;
            else if (sclk[i] && !sclk_prev[i]) rises[i] <= rises[i] + 1;
            if (!cs_n[i] && cs_prev[i]) cur_word[i] <= adc_word[i];
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            sdo[i] = 1'b0;
            if (rises[i] < 16) sdo[i] = cur_word[i][15 - rises[i]];
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (strobe[i]) check($sformatf("strobe_single%0d", i), 32'(strobe_prev[i]), 32'd0);
            strobe_prev[i] = strobe[i];
        end
    end

    function automatic logic [15:0] ref_signed(input logic [15:0] w);
        return 16'(int'(w) - 32768);
    endfunction

    task automatic wait_fall(input int i, input int budget, output int at, output bit ok);
        logic prev;
        prev = cs_n[i];
        ok   = 1'b0;
        at   = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (!cs_n[i] && prev) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
            prev = cs_n[i];
        end
    endtask

    task automatic wait_strobe(input int i, input int budget, output int at, output bit ok,
                               output int rmax);
        ok   = 1'b0;
        at   = -1;
        rmax = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (rises[i] > rmax) rmax = rises[i];
            if (strobe[i]) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    vec_t tab[NV];
    int   base, f, s, prev_s, rm, t, nr;
    bit   ok;
    logic sp;

    initial begin
        tab[0] = '{16'hA5C3, 16'h25C3, 16'hA5C3};
        tab[1] = '{16'h0000, 16'h8000, 16'h0000};
        tab[2] = '{16'hFFFF, 16'h7FFF, 16'hFFFF};
        tab[3] = '{16'h8000, 16'h0000, 16'h8000};
        for (int k = 4; k < NV; k++) begin
            tab[k].word  = 16'($urandom);
            tab[k].exp_s = ref_signed(tab[k].word);
            tab[k].exp_u = tab[k].word;
        end
        for (int i = 0; i < 3; i++) begin
            en[i] = 1'b0;
            clr[i] = 1'b0;
            adc_word[i] = 16'h0;
            strobe_prev[i] = 1'b0;
        end
        adc_word[0] = tab[0].word;
        adc_word[1] = tab[0].word;

        repeat (3) @(negedge clk);
        check("rst_cs_n", 32'(cs_n[0]), 32'd1);
        check("rst_sclk", 32'(sclk[0]), 32'd0);
        check("rst_sample", 32'(sample[0]), 32'd0);
        check("rst_strobe", 32'(strobe[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_overrun", 32'(ovr[0]), 32'd0);

        // Continuous conversions on the default-period instances.
        en[0] = 1'b1;
        en[1] = 1'b1;
        rst_n = 1'b1;
        base = cyc;
        prev_s = 0;
        for (int j = 0; j < NV; j++) begin
            wait_fall(0, P + 10, f, ok);
            check("fall_found", 32'(ok), 32'd1);
            check("fall_cycle", 32'(f), 32'(base + j * P + 1));
            wait_strobe(0, 200, s, ok, rm);
            check("strobe_found", 32'(ok), 32'd1);
            check("latency", 32'(s - f), 32'(LAT));
            check("sample_signed", 32'(sample[0]), 32'(tab[j].exp_s));
            check("sample_unsigned", 32'(sample[1]), 32'(tab[j].exp_u));
            check("strobe_pair", 32'(strobe[1]), 32'd1);
            check("sclk_rises", 32'(rm), 32'd16);
            check("no_overrun", 32'(ovr[0]), 32'd0);
            if (j > 0) check("strobe_spacing", 32'(s - prev_s), 32'(P));
            prev_s = s;
            if (j + 1 < NV) begin
                adc_word[0] = tab[j + 1].word;
                adc_word[1] = tab[j + 1].word;
            end
        end

        // Enable dropped mid-conversion, then re-enabled off-tick.
        en[1] = 1'b0;
        adc_word[0] = 16'h1234;
        wait_fall(0, P + 10, f, ok);
        check("t4_fall", 32'(f), 32'(base + NV * P + 1));
        repeat (10) @(negedge clk);
        en[0] = 1'b0;
        wait_strobe(0, 200, s, ok, rm);
        check("t4_strobe", 32'(s), 32'(f + LAT));
        check("t4_sample", 32'(sample[0]), 32'(ref_signed(16'h1234)));
        repeat (5) @(negedge clk);
        check("t4_sample_held", 32'(sample[0]), 32'(ref_signed(16'h1234)));
        wait_fall(0, 3 * P, f, ok);
        check("t4_no_start_disabled", 32'(ok), 32'd0);
        en[0] = 1'b1;
        t = base + ((cyc - base + P - 1) / P) * P;
        wait_fall(0, P + 10, f, ok);
        check("t4_restart_at_tick", 32'(f), 32'(t + 1));
        wait_strobe(0, 200, s, ok, rm);
        check("t4_restart_sample", 32'(sample[0]), 32'(ref_signed(16'h1234)));

        // Short period: conversion spans two ticks.
        adc_word[2] = 16'h0F0F;
        en[2] = 1'b1;
        t = base + ((cyc - base + P2 - 1) / P2) * P2;
        wait_fall(2, 100, f, ok);
        check("t3_fall", 32'(f), 32'(t + 1));
        wait_to(t + 64);
        check("t3_ovr_before", 32'(ovr[2]), 32'd0);
        @(negedge clk);
        check("t3_ovr_set", 32'(ovr[2]), 32'd1);
        wait_strobe(2, 200, s, ok, rm);
        check("t3_strobe", 32'(s), 32'(t + 1 + LAT));
        check("t3_sample", 32'(sample[2]), 32'(ref_signed(16'h0F0F)));
        check("t3_ovr_sticky", 32'(ovr[2]), 32'd1);
        wait_fall(2, 100, f, ok);
        check("t3_next_start", 32'(f), 32'(t + 3 * P2 + 1));
        wait_to(t + 200);
        clr[2] = 1'b1;
        @(negedge clk);
        clr[2] = 1'b0;
        check("t3_ovr_cleared", 32'(ovr[2]), 32'd0);
        wait_to(t + 4 * P2);
        check("t3_ovr_pre_collide", 32'(ovr[2]), 32'd0);
        clr[2] = 1'b1;
        @(negedge clk);
        clr[2] = 1'b0;
        check("t3_set_beats_clr", 32'(ovr[2]), 32'd1);
        en[2] = 1'b0;

        // Reset in the middle of a conversion.
        adc_word[0] = 16'h5A3C;
        wait_fall(0, P + 10, f, ok);
        check("t5_fall_found", 32'(ok), 32'd1);
        nr = 0;
        sp = sclk[0];
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (sclk[0] && !sp) nr++;
            sp = sclk[0];
            if (nr == 8) break;
        end
        check("t5_eighth_rise", 32'(nr), 32'd8);
        #1 rst_n = 1'b0;
        #1;
        check("t5_cs_n", 32'(cs_n[0]), 32'd1);
        check("t5_sclk", 32'(sclk[0]), 32'd0);
        check("t5_busy", 32'(busy[0]), 32'd0);
        check("t5_strobe", 32'(strobe[0]), 32'd0);
        check("t5_sample", 32'(sample[0]), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t5_no_strobe_in_reset", 32'(strobe[0]), 32'd0);
        end
        rst_n = 1'b1;
        base = cyc;
        wait_fall(0, P + 10, f, ok);
        check("t5_fall_after_reset", 32'(f), 32'(base + 1));
        wait_strobe(0, 200, s, ok, rm);
        check("t5_strobe_after_reset", 32'(s), 32'(f + LAT));
        check("t5_sample_after_reset", 32'(sample[0]), 32'(ref_signed(16'h5A3C)));
        check("t5_rises", 32'(rm), 32'd16);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
